// File: rtl/regs_io.sv
// Register file with switch/LED mapping and a debounced button handshake that stalls the PC
// until the user presses and releases the button.
module regs_io #(
   parameter int unsigned N   = 8,
   parameter int unsigned A   = 3,
   parameter int unsigned DEB = 4
) (
   input  logic                clk,
   input  logic                nReset,
   input  logic [A-1:0]        raddr1_i,
   input  logic [A-1:0]        raddr2_i,
   output logic signed [N-1:0] rdata1_o,
   output logic signed [N-1:0] rdata2_o,
   input  logic [A-1:0]        waddr_i,
   input  logic [N-1:0]        wdata_i,
   input  logic                we_i,
   input  logic [N-1:0]        sw_i,
   input  logic                btn_i,
   input  logic                wait_req_i,
   output logic                stall_o,
   output logic [N-1:0]        leds_o
);

   localparam int unsigned NumRegs = 2 ** A;
   localparam int unsigned CntW    = $clog2(DEB + 1);

   typedef enum logic [1:0] {StIdle, StWaitPress, StWaitRelease} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    rf_q [2:NumRegs-1];
   logic [N-1:0]    sw_meta_q, sw_sync_q, sw_cap_q;
   logic            btn_meta_q, btn_sync_q, btn_clean_q, btn_clean_d, btn_prev_q;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            press, write_en;

   assign press    = btn_clean_q & ~btn_prev_q;
   assign write_en = we_i & ~stall_o;
   assign leds_o   = rf_q[NumRegs-1];
   assign cnt_inc  = cnt_q + CntW'(1);

   // Counter only runs while the synchronised level disagrees with the clean level.
   always_comb begin
      cnt_d       = '0;
      btn_clean_d = btn_clean_q;
      if (btn_sync_q != btn_clean_q) begin
         if (cnt_inc == CntW'(DEB)) begin
            btn_clean_d = btn_sync_q;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         sw_meta_q   <= '0;
         sw_sync_q   <= '0;
         btn_meta_q  <= 1'b0;
         btn_sync_q  <= 1'b0;
         btn_clean_q <= 1'b0;
         btn_prev_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sw_meta_q   <= sw_i;
         sw_sync_q   <= sw_meta_q;
         btn_meta_q  <= btn_i;
         btn_sync_q  <= btn_meta_q;
         btn_clean_q <= btn_clean_d;
         btn_prev_q  <= btn_clean_q;
         cnt_q       <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:        if (wait_req_i)   state_d = StWaitPress;
         StWaitPress:   if (press)        state_d = StWaitRelease;
         StWaitRelease: if (!btn_clean_q) state_d = StIdle;
         default:                         state_d = StIdle;
      endcase
   end

   always_comb begin
      stall_o = 1'b0;
      unique case (state_q)
         StIdle:        stall_o = wait_req_i;
         StWaitPress:   stall_o = 1'b1;
         StWaitRelease: stall_o = btn_clean_q;
         default:       stall_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         sw_cap_q <= '0;
      end else if (state_q == StWaitPress && press) begin
         sw_cap_q <= sw_sync_q;
      end
   end

   // r0 and r1 have no storage, so writes to them fall through the loop.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         for (int unsigned i = 2; i < NumRegs; i++) rf_q[i] <= '0;
      end else if (write_en) begin
         for (int unsigned i = 2; i < NumRegs; i++) begin
            if (waddr_i == A'(i)) rf_q[i] <= wdata_i;
         end
      end
   end

   always_comb begin
      rdata1_o = '0;
      rdata2_o = '0;
      if (raddr1_i == A'(1)) rdata1_o = sw_cap_q;
      if (raddr2_i == A'(1)) rdata2_o = sw_cap_q;
      for (int unsigned i = 2; i < NumRegs; i++) begin
         if (raddr1_i == A'(i)) rdata1_o = rf_q[i];
         if (raddr2_i == A'(i)) rdata2_o = rf_q[i];
      end
   end

endmodule
